mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage; the consumer end of the EXE→MEM valid/allowin handshake.
- Latches the EXE payload and waits for the data-RAM response when EXE issued a request.
- Aligns and extends load data, then hands the final result to WB.
- Publishes a forwarding/blocking bundle back to ID.

Parameters:
none (datapath fixed at 32 bits, 32 registers)

Ports:
clk  in  1  clock
resetn  in  1  reset
exe_to_mem_valid  in  1  EXE holds a valid instruction ready to transfer
mem_allowin  out  1  MEM can accept this cycle
exe_pc  in  32  instruction PC
exe_result  in  32  ALU/mul/div result; for memory ops, the byte address
exe_res_from_mem  in  1  instruction is a load
exe_ld_op  in  4  {ld_b, ld_h, ld_w, ld_ue}; ld_ue=1 means zero-extend
exe_req_sent  in  1  EXE issued a data-RAM request (load or store)
exe_rf_all  in  6  {rf_we, rf_waddr[4:0]}
data_sram_data_ok  in  1  one-cycle pulse: response for the outstanding request
data_sram_rdata  in  32  read data, valid with data_ok
wb_allowin  in  1  WB can accept
mem_to_wb_valid  out  1  valid transfer to WB
mem_pc  out  32  latched PC
mem_final_result  out  32  aligned/extended load data, or latched exe_result
mem_rf_we  out  1  register write enable (gated by mem_valid)
mem_rf_waddr  out  5  destination register
mem_fwd_all  out  39  {mem_block, mem_rf_we, mem_rf_waddr, mem_final_result}

Behaviour:
- Reset is synchronous, active-low, on resetn; clock is clk.
- Reset values: mem_valid=0, wait_resp=0, buf_valid=0, all payload regs 0. Outputs: mem_to_wb_valid=0, mem_rf_we=0, mem_allowin=1, mem_pc=0, mem_final_result=0.
- Handshake:
  - mem_ready_go = ~wait_resp | data_sram_data_ok | buf_valid.
  - mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin).
  - mem_to_wb_valid = mem_valid & mem_ready_go.
  - On exe_to_mem_valid & mem_allowin, latch the payload and set mem_valid=1.
  - Also on that transfer: wait_resp = exe_req_sent, buf_valid = 0.
  - Else if mem_allowin: mem_valid <= 0.
- Response tracking:
  - data_ok while mem_valid & wait_resp & ~buf_valid, with WB not taking the instruction: capture rdata into data_buf, set buf_valid=1, clear wait_resp.
  - data_ok in the same cycle the instruction leaves: no capture needed; data goes straight through.
  - data_ok when not waiting (mem_valid=0, wait_resp=0, or buf_valid=1): ignored. Verification flags it as a protocol error.
- Raw data = buf_valid ? data_buf : data_sram_rdata.
- Load alignment (off = mem exe_result[1:0]):
  - ld_b: byte at off (0→[7:0] … 3→[31:24]); sign-extend bit 7, or zero-extend if ld_ue.
  - ld_h: off[1]=0 → [15:0], off[1]=1 → [31:16]; sign/zero-extend per ld_ue. off[0] is ignored.
  - ld_w: full word; off ignored.
- mem_final_result: aligned load data if res_from_mem, else latched exe_result. Stores (req_sent, not a load) still wait for data_ok but pass exe_result.
- mem_block = mem_valid & res_from_mem & ~mem_ready_go. ID must stall a dependent instruction while this is 1.
- mem_rf_we = mem_valid & latched rf_we. Forwarding data is meaningful only when mem_block=0.
- Latency: 1 cycle minimum per instruction; unbounded while waiting for data_ok.
- Back-to-back: a new instruction may enter in the same cycle the previous one leaves. Its wait_resp is loaded from its own exe_req_sent, and buf_valid clears.
- Reset mid-wait: all state clears. A data_ok arriving afterwards is ignored.

Test Plan:
- ALU passthrough: exe_result=0x1234_5678, req_sent=0, rf_all={1,5}, wb_allowin=1 → next cycle mem_to_wb_valid=1, mem_final_result=0x1234_5678, mem_rf_waddr=5, mem_block=0.
- ld_b sign/zero: addr=…03, rdata=0x80FF_0011, data_ok 2 cycles after entry → ld_b gives 0xFFFF_FF80, ld_b+ue gives 0x0000_0080. mem_block=1 until data_ok.
- ld_h upper: addr=…02, rdata=0x8001_7FFF → ld_h gives 0xFFFF_8001. With addr=…00 → 0x0000_7FFF.
- WB stall capture: ld_w, data_ok with rdata=0xDEAD_BEEF while wb_allowin=0 for 3 cycles → buffer held. On release, result=0xDEAD_BEEF; mem_allowin=0 throughout the stall.
- Store: req_sent=1, res_from_mem=0, data_ok after 4 cycles → ready_go asserts only on data_ok, result=exe_result, mem_block stays 0.
- Reset during wait: ld_w outstanding, resetn=0 for one cycle, then a spurious data_ok → mem_valid=0, no WB transfer, mem_allowin=1.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the EXE payload, waits for the data-RAM
// response when a request was issued, aligns/extends load data and hands it to WB.
`timescale 1ns/1ps

module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exe_to_mem_valid,
    output logic        mem_allowin,
    input  logic [31:0] exe_pc,
    input  logic [31:0] exe_result,
    input  logic        exe_res_from_mem,
    input  logic [3:0]  exe_ld_op,
    input  logic        exe_req_sent,
    input  logic [5:0]  exe_rf_all,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        wb_allowin,
    output logic        mem_to_wb_valid,
    output logic [31:0] mem_pc,
    output logic [31:0] mem_final_result,
    output logic        mem_rf_we,
    output logic [4:0]  mem_rf_waddr,
    output logic [38:0] mem_fwd_all
);

    logic        mem_valid_r;
    logic        wait_resp_r;
    logic        buf_valid_r;
    logic [31:0] data_buf_r;
    logic [31:0] pc_r;
    logic [31:0] result_r;
    logic        res_from_mem_r;
    logic [3:0]  ld_op_r;
    logic        rf_we_r;
    logic [4:0]  rf_waddr_r;

    logic        mem_ready_go_s;
    logic        mem_leave_s;
    logic        exe_accept_s;
    logic        resp_capture_s;
    logic        mem_block_s;
    logic        mem_rf_we_s;
    logic [31:0] raw_data_s;
    logic [31:0] final_result_s;

    // ld_op is {ld_b, ld_h, ld_w, ld_ue}; ld_ue selects zero extension.
    function automatic logic [31:0] align_load(
        input logic [31:0] raw,
        input logic [1:0]  off,
        input logic [3:0]  ld_op
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res_v;
        case (off)
            2'd0:    byte_v = raw[7:0];
            2'd1:    byte_v = raw[15:8];
            2'd2:    byte_v = raw[23:16];
            2'd3:    byte_v = raw[31:24];
            default: byte_v = raw[7:0];
        endcase
        half_v = off[1] ? raw[31:16] : raw[15:0];
        if (ld_op[3]) begin
            res_v = ld_op[0] ? {24'h00_0000, byte_v} : {{24{byte_v[7]}}, byte_v};
        end else if (ld_op[2]) begin
            res_v = ld_op[0] ? {16'h0000, half_v} : {{16{half_v[15]}}, half_v};
        end else if (ld_op[1]) begin
            res_v = raw;
        end else begin
            res_v = raw;
        end
        return res_v;
    endfunction

    assign mem_ready_go_s = ~wait_resp_r | data_sram_data_ok | buf_valid_r;
    assign mem_allowin    = ~mem_valid_r | (mem_ready_go_s & wb_allowin);
    assign mem_leave_s    = mem_valid_r & mem_ready_go_s & wb_allowin;
    assign exe_accept_s   = exe_to_mem_valid & mem_allowin;
    // A response only needs buffering when the instruction cannot leave this cycle.
    assign resp_capture_s = mem_valid_r & wait_resp_r & ~buf_valid_r
                          & data_sram_data_ok & ~mem_leave_s;

    // Stage valid bit and response-tracking flags.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid_r <= 1'b0;
            wait_resp_r <= 1'b0;
            buf_valid_r <= 1'b0;
        end else if (exe_accept_s) begin
            mem_valid_r <= 1'b1;
            wait_resp_r <= exe_req_sent;
            buf_valid_r <= 1'b0;
        end else if (mem_allowin) begin
            mem_valid_r <= 1'b0;
            wait_resp_r <= 1'b0;
            buf_valid_r <= 1'b0;
        end else if (resp_capture_s) begin
            mem_valid_r <= mem_valid_r;
            wait_resp_r <= 1'b0;
            buf_valid_r <= 1'b1;
        end else begin
            mem_valid_r <= mem_valid_r;
            wait_resp_r <= wait_resp_r;
            buf_valid_r <= buf_valid_r;
        end
    end

    // Holds read data that arrived while WB was stalled.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_buf_r <= 32'h0000_0000;
        end else if (resp_capture_s) begin
            data_buf_r <= data_sram_rdata;
        end else begin
            data_buf_r <= data_buf_r;
        end
    end

    // Instruction payload latched on transfer from EXE.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_r           <= 32'h0000_0000;
            result_r       <= 32'h0000_0000;
            res_from_mem_r <= 1'b0;
            ld_op_r        <= 4'b0000;
            rf_we_r        <= 1'b0;
            rf_waddr_r     <= 5'd0;
        end else if (exe_accept_s) begin
            pc_r           <= exe_pc;
            result_r       <= exe_result;
            res_from_mem_r <= exe_res_from_mem;
            ld_op_r        <= exe_ld_op;
            rf_we_r        <= exe_rf_all[5];
            rf_waddr_r     <= exe_rf_all[4:0];
        end else begin
            pc_r           <= pc_r;
            result_r       <= result_r;
            res_from_mem_r <= res_from_mem_r;
            ld_op_r        <= ld_op_r;
            rf_we_r        <= rf_we_r;
            rf_waddr_r     <= rf_waddr_r;
        end
    end

    // Result selection: buffered data wins once captured, otherwise the live bus.
    always_comb begin
        raw_data_s     = 32'h0000_0000;
        final_result_s = 32'h0000_0000;
        if (buf_valid_r) begin
            raw_data_s = data_buf_r;
        end else begin
            raw_data_s = data_sram_rdata;
        end
        if (res_from_mem_r) begin
            final_result_s = align_load(raw_data_s, result_r[1:0], ld_op_r);
        end else begin
            final_result_s = result_r;
        end
    end

    assign mem_block_s      = mem_valid_r & res_from_mem_r & ~mem_ready_go_s;
    assign mem_rf_we_s      = mem_valid_r & rf_we_r;

    assign mem_to_wb_valid  = mem_valid_r & mem_ready_go_s;
    assign mem_pc           = pc_r;
    assign mem_final_result = final_result_s;
    assign mem_rf_we        = mem_rf_we_s;
    assign mem_rf_waddr     = rf_waddr_r;
    assign mem_fwd_all      = {mem_block_s, mem_rf_we_s, rf_waddr_r, final_result_s};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: randomized EXE traffic, a data-RAM responder
// and a WB sink, checked against a load-alignment reference model.
`timescale 1ns/1ps

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        exe_to_mem_valid;
    logic        mem_allowin;
    logic [31:0] exe_pc;
    logic [31:0] exe_result;
    logic        exe_res_from_mem;
    logic [3:0]  exe_ld_op;
    logic        exe_req_sent;
    logic [5:0]  exe_rf_all;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        wb_allowin;
    logic        mem_to_wb_valid;
    logic [31:0] mem_pc;
    logic [31:0] mem_final_result;
    logic        mem_rf_we;
    logic [4:0]  mem_rf_waddr;
    logic [38:0] mem_fwd_all;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .resetn(resetn),
        .exe_to_mem_valid(exe_to_mem_valid), .mem_allowin(mem_allowin),
        .exe_pc(exe_pc), .exe_result(exe_result), .exe_res_from_mem(exe_res_from_mem),
        .exe_ld_op(exe_ld_op), .exe_req_sent(exe_req_sent), .exe_rf_all(exe_rf_all),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .wb_allowin(wb_allowin), .mem_to_wb_valid(mem_to_wb_valid), .mem_pc(mem_pc),
        .mem_final_result(mem_final_result), .mem_rf_we(mem_rf_we),
        .mem_rf_waddr(mem_rf_waddr), .mem_fwd_all(mem_fwd_all)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] res;
        logic        is_load;
        logic [3:0]  ld_op;
        logic        req;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] rdata;
        int          delay;
        int          wb_stall;
        logic        has_exp;
        logic [31:0] exp_res;
    } stim_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] result;
        logic        is_load;
        logic        req;
        logic        rf_we;
        logic [4:0]  waddr;
    } exp_t;

    stim_t       stim_q[$];
    exp_t        sb[$];
    stim_t       cur;
    int          checks = 0;
    int          failures = 0;
    logic        mon_en = 1'b0;
    logic        resp_pend = 1'b0;
    logic        resp_done = 1'b0;
    int          resp_cnt = 0;
    logic [31:0] resp_data = 32'h0;
    int          stall_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: pick the byte/half named by the address, then extend.
    function automatic logic [31:0] ref_load(input stim_t s);
        logic [1:0]  off;
        logic [7:0]  b;
        logic [15:0] h;
        off = s.res[1:0];
        b = s.rdata[8*off +: 8];
        h = s.rdata[16*off[1] +: 16];
        if (s.ld_op[3]) return s.ld_op[0] ? {24'h0, b} : {{24{b[7]}}, b};
        else if (s.ld_op[2]) return s.ld_op[0] ? {16'h0, h} : {{16{h[15]}}, h};
        else return s.rdata;
    endfunction

    task automatic add(input logic [31:0] pc, input logic [31:0] res, input logic is_load,
                       input logic [3:0] ld_op, input logic req, input logic rf_we,
                       input logic [4:0] waddr, input logic [31:0] rdata, input int delay,
                       input int wb_stall, input logic has_exp, input logic [31:0] exp_res);
        stim_t s;
        s.pc = pc; s.res = res; s.is_load = is_load; s.ld_op = ld_op; s.req = req;
        s.rf_we = rf_we; s.waddr = waddr; s.rdata = rdata; s.delay = delay;
        s.wb_stall = wb_stall; s.has_exp = has_exp; s.exp_res = exp_res;
        stim_q.push_back(s);
    endtask

    // One clock of EXE driver, data-RAM responder and WB sink.
    task automatic step(input bit allow_issue);
        logic acc;
        exp_t e;
        @(negedge clk);
        acc = exe_to_mem_valid && mem_allowin;
        @(posedge clk);
        #1;
        if (acc) begin
            e.pc = cur.pc; e.is_load = cur.is_load; e.req = cur.req;
            e.rf_we = cur.rf_we; e.waddr = cur.waddr;
            e.result = cur.has_exp ? cur.exp_res : (cur.is_load ? ref_load(cur) : cur.res);
            sb.push_back(e);
            resp_done = 1'b0;
            if (cur.req) begin
                resp_pend = 1'b1; resp_cnt = cur.delay; resp_data = cur.rdata;
            end
            stall_cnt = cur.wb_stall;
            exe_to_mem_valid = 1'b0;
        end
        if (resp_pend && resp_cnt == 0) begin
            data_sram_data_ok = 1'b1; data_sram_rdata = resp_data;
            resp_pend = 1'b0; resp_done = 1'b1;
        end else if (resp_pend) begin
            resp_cnt--;
            data_sram_data_ok = 1'b0; data_sram_rdata = $urandom;
        end else begin
            data_sram_data_ok = ($urandom_range(7, 0) == 0);
            data_sram_rdata = $urandom;
        end
        if (stall_cnt > 0) begin
            wb_allowin = 1'b0; stall_cnt--;
        end else begin
            wb_allowin = ($urandom_range(3, 0) != 0);
        end
        if (!exe_to_mem_valid) begin
            if (allow_issue && stim_q.size() > 0 && $urandom_range(2, 0) != 0) begin
                cur = stim_q.pop_front();
                exe_pc = cur.pc; exe_result = cur.res; exe_res_from_mem = cur.is_load;
                exe_ld_op = cur.ld_op; exe_req_sent = cur.req;
                exe_rf_all = {cur.rf_we, cur.waddr};
                exe_to_mem_valid = 1'b1;
            end else begin
                exe_pc = $urandom; exe_result = $urandom; exe_res_from_mem = $urandom;
                exe_ld_op = $urandom; exe_req_sent = $urandom; exe_rf_all = $urandom;
            end
        end
    endtask

    // Monitor: compares the instruction at the head of the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic rdy;
        if (mon_en) begin
            if (sb.size() != 0) begin
                e = sb[0];
                rdy = !e.req || data_sram_data_ok || resp_done;
                chk("to_wb_valid", mem_to_wb_valid, rdy);
                chk("allowin", mem_allowin, rdy && wb_allowin);
                chk("mem_block", mem_fwd_all[38], e.is_load && !rdy);
                chk("rf_we", mem_rf_we, e.rf_we);
                chk("rf_waddr", mem_rf_waddr, e.waddr);
                chk("pc", mem_pc, e.pc);
                if (rdy) begin
                    chk("final_result", mem_final_result, e.result);
                    chk("fwd_all", mem_fwd_all, {1'b0, e.rf_we, e.waddr, e.result});
                    if (wb_allowin) void'(sb.pop_front());
                end
            end else begin
                chk("idle_valid", mem_to_wb_valid, 1'b0);
                chk("idle_allowin", mem_allowin, 1'b1);
                chk("idle_rf_we", mem_rf_we, 1'b0);
                chk("idle_block", mem_fwd_all[38], 1'b0);
            end
        end
    end

    initial begin
        int sel, kind;
        logic ue;
        resetn = 1'b0; exe_to_mem_valid = 1'b0; exe_pc = 32'h0; exe_result = 32'h0;
        exe_res_from_mem = 1'b0; exe_ld_op = 4'b0; exe_req_sent = 1'b0; exe_rf_all = 6'b0;
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0; wb_allowin = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", mem_to_wb_valid, 1'b0);
        chk("rst_allowin", mem_allowin, 1'b1);
        chk("rst_pc", mem_pc, 32'h0);
        chk("rst_result", mem_final_result, 32'h0);
        chk("rst_rf_we", mem_rf_we, 1'b0);
        @(posedge clk); #1;
        resetn = 1'b1; mon_en = 1'b1;

        add(32'h1c00_0000, 32'h1234_5678, 1'b0, 4'b0000, 1'b0, 1'b1, 5'd5, 32'h0, 0, 0, 1'b1, 32'h1234_5678);
        add(32'h1c00_0004, 32'h1000_0003, 1'b1, 4'b1000, 1'b1, 1'b1, 5'd6, 32'h80FF_0011, 1, 0, 1'b1, 32'hFFFF_FF80);
        add(32'h1c00_0008, 32'h1000_0003, 1'b1, 4'b1001, 1'b1, 1'b1, 5'd7, 32'h80FF_0011, 1, 0, 1'b1, 32'h0000_0080);
        add(32'h1c00_000c, 32'h1000_0002, 1'b1, 4'b0100, 1'b1, 1'b1, 5'd8, 32'h8001_7FFF, 2, 0, 1'b1, 32'hFFFF_8001);
        add(32'h1c00_0010, 32'h1000_0000, 1'b1, 4'b0100, 1'b1, 1'b1, 5'd9, 32'h8001_7FFF, 0, 0, 1'b1, 32'h0000_7FFF);
        add(32'h1c00_0014, 32'h1000_0010, 1'b1, 4'b0010, 1'b1, 1'b1, 5'd10, 32'hDEAD_BEEF, 0, 4, 1'b1, 32'hDEAD_BEEF);
        add(32'h1c00_0018, 32'h1000_0040, 1'b0, 4'b0000, 1'b1, 1'b0, 5'd0, 32'h5555_AAAA, 3, 0, 1'b1, 32'h1000_0040);

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(2, 0);
            sel = $urandom_range(2, 0);
            ue = $urandom;
            add({$urandom_range(32'h0fff_ffff, 0), 2'b00}, $urandom, kind == 2,
                (kind == 2) ? {sel == 0, sel == 1, sel == 2, ue} : 4'b0000,
                kind != 0, $urandom, $urandom, $urandom, $urandom_range(4, 0),
                ($urandom_range(3, 0) == 0) ? $urandom_range(3, 1) : 0, 1'b0, 32'h0);
        end

        for (int i = 0; i < 6000 && (stim_q.size() > 0 || exe_to_mem_valid); i++) step(1'b1);
        for (int i = 0; i < 200 && sb.size() > 0; i++) step(1'b0);
        chk("all_issued", stim_q.size(), 0);
        chk("drained", sb.size(), 0);

        cur.pc = 32'h1c00_1000; cur.res = 32'h2000_0000; cur.is_load = 1'b1; cur.ld_op = 4'b0010;
        cur.req = 1'b1; cur.rf_we = 1'b1; cur.waddr = 5'd3; cur.rdata = 32'hCAFE_F00D;
        cur.delay = 1000; cur.wb_stall = 0; cur.has_exp = 1'b0; cur.exp_res = 32'h0;
        exe_pc = cur.pc; exe_result = cur.res; exe_res_from_mem = 1'b1; exe_ld_op = cur.ld_op;
        exe_req_sent = 1'b1; exe_rf_all = {1'b1, 5'd3}; exe_to_mem_valid = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0);
        chk("wait_entered", sb.size(), 1);
        resetn = 1'b0; data_sram_data_ok = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1; sb.delete(); resp_pend = 1'b0; resp_done = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_ABCD; wb_allowin = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", mem_to_wb_valid, 1'b0);
        chk("post_rst_allowin", mem_allowin, 1'b1);
        chk("post_rst_block", mem_fwd_all[38], 1'b0);
        @(posedge clk); #1;
        data_sram_data_ok = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
